uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries; legal values are the powers of 2 from 2 to 16.
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 640, meaning the idle character timeout in baud_tick pulses (4 chars x 10 bits x 16).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk in, reset_n in.
REQ-004 clk  in  1  system clock; all logic rises on posedge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 baud_tick  in  1  one-clk pulse at 16x the baud rate.
REQ-007 rx_stop_strobe  in  1  one-clk pulse from the receiver: byte complete.
REQ-008 rx_byte  in  8  received byte, valid with rx_stop_strobe.
REQ-009 rx_parity_err  in  1  receiver parity error flag, valid with rx_stop_strobe.
REQ-010 rx_framing_err  in  1  receiver framing error pulse.
REQ-011 rx_idle  in  1  receiver in its idle state.
REQ-012 rx_read_byte  out  1  one-clk acknowledge to the receiver; clears its data-ready.
REQ-013 rx_clear_parity  out  1  one-clk pulse that clears the receiver parity flag.
REQ-014 rd_en  in  1  host pop request.
REQ-015 rd_data  out  8  FIFO head byte (show-ahead).
REQ-016 rd_valid  out  1  FIFO not empty.
REQ-017 level  out  5  FIFO occupancy, 0..FIFO_DEPTH.
REQ-018 thresh  in  5  interrupt level threshold; 0 disables the level source.
REQ-019 irq_en  in  1  global interrupt enable.
REQ-020 clr_status  in  1  one-clk pulse that clears all sticky flags.
REQ-021 status  out  4  sticky {timeout, framing_err, parity_err, overflow}, MSB first.
REQ-022 irq  out  1  registered interrupt.

Function
REQ-023 The FSM SHALL have three states: IDLE, CAPTURE and ACK.
REQ-024 FSM transitions SHALL be: IDLE->CAPTURE when rx_stop_strobe=1; CAPTURE->ACK unconditionally; ACK->IDLE unconditionally.
REQ-025 On the CAPTURE clock edge, rx_byte and rx_parity_err, registered at strobe, SHALL be written to the tail if the FIFO is not full; otherwise the byte is discarded and overflow is set.
REQ-026 In ACK, rx_read_byte SHALL be 1 for exactly one clk; rx_clear_parity SHALL be 1 in the same cycle only if the captured parity error was 1.
REQ-027 Latency: a strobe in cycle N SHALL give rd_valid=1 in cycle N+2 (not full) and rx_read_byte=1 in cycle N+2.
REQ-028 A rx_stop_strobe while in CAPTURE or ACK SHALL set overflow, discard the byte, and leave the state unchanged.
REQ-029 When rd_en=1 and not empty, the FIFO SHALL advance the head on that edge; rd_en when empty SHALL be ignored with no flag.
REQ-030 A push and a pop on the same edge SHALL both take effect, including when full: level is unchanged and there is no overflow.
REQ-031 When empty, rd_data SHALL be 8'h00.
REQ-032 Head and tail pointers SHALL wrap modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH.
REQ-033 The parity_err sticky flag SHALL be set when a popped entry carries parity error=1.
REQ-034 The framing_err sticky flag SHALL be set on rx_framing_err=1.
REQ-035 The timeout counter SHALL increment on baud_tick while level>0, rx_idle=1 and there is no push or pop.
REQ-036 The timeout counter SHALL clear on any push, any pop, or level=0.
REQ-037 The timeout flag SHALL be set when the count reaches TIMEOUT_TICKS-1; the counter SHALL then hold until cleared.
REQ-038 clr_status SHALL clear all sticky flags; a set event in the same cycle SHALL win.
REQ-039 irq SHALL register irq_en & ((thresh!=0 & level>=thresh) | any status bit), with one clk of delay.

Reset
REQ-040 reset_n=0 SHALL asynchronously force: state=IDLE, pointers=0, level=0, rd_valid=0, rd_data=8'h00, rx_read_byte=0, rx_clear_parity=0, status=4'b0000, timeout counter=0, irq=0.
REQ-041 Reset during CAPTURE or ACK SHALL abandon the byte, with no rx_read_byte pulse after release.

Verification
REQ-042 Strobe with rx_byte=8'hA5, parity_err=0 -> rd_valid=1, rd_data=8'hA5 and one rx_read_byte pulse 2 clk later; rx_clear_parity stays 0.
REQ-043 FIFO_DEPTH=4: five strobes with no pops -> level=4 and status=4'b0001; pops return the first four bytes in order.
REQ-044 FIFO full with a strobe and rd_en in the same CAPTURE cycle -> level stays 4, overflow=0, and the new byte is at the tail.
REQ-045 One byte, rx_idle=1, 640 baud_ticks with no pop -> status[3]=1 and irq=1 next clk (irq_en=1); clr_status -> status=0 and irq=0.
REQ-046 thresh=2: push byte 1 -> irq=0; push byte 2 -> irq=1; pop -> irq=0.
REQ-047 Strobe with parity_err=1 -> rx_clear_parity pulses in ACK; on pop, status[1]=1.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Sits between a UART byte receiver and a host. Each completed byte is
//   captured, acknowledged back to the receiver, and queued in a small
//   show-ahead FIFO. Sticky status flags and a registered interrupt cover
//   overflow, parity, framing and idle-character timeout.
//
// Ports
//   clk, reset_n        system clock / asynchronous active-low reset
//   baud_tick           16x baud pulse, drives the idle timeout counter
//   rx_stop_strobe      receiver byte-complete pulse
//   rx_byte             received byte (valid with rx_stop_strobe)
//   rx_parity_err       parity error for that byte (valid with strobe)
//   rx_framing_err      receiver framing error pulse
//   rx_idle             receiver line idle
//   rx_read_byte        one-clk acknowledge to the receiver
//   rx_clear_parity     one-clk pulse clearing the receiver parity flag
//   rd_en               host pop request
//   rd_data             FIFO head byte, 8'h00 when empty
//   rd_valid            FIFO not empty
//   level               FIFO occupancy 0..FIFO_DEPTH
//   thresh              level interrupt threshold, 0 disables
//   irq_en              global interrupt enable
//   clr_status          clears all sticky flags
//   status              sticky {timeout, framing_err, parity_err, overflow}
//   irq                 registered interrupt
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   IDLE     | waiting for rx_stop_strobe
//   CAPTURE  | byte latched; written to FIFO tail on this edge
//   ACK      | rx_read_byte (and optional rx_clear_parity) asserted
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic       rx_stop_strobe,
  input  logic [7:0] rx_byte,
  input  logic       rx_parity_err,
  input  logic       rx_framing_err,
  input  logic       rx_idle,
  output logic       rx_read_byte,
  output logic       rx_clear_parity,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [4:0] level,
  input  logic [4:0] thresh,
  input  logic       irq_en,
  input  logic       clr_status,
  output logic [3:0] status,
  output logic       irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_TICKS - 1);
  localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_ACK} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cap_byte_q, cap_byte_d;
  logic            cap_par_q, cap_par_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [4:0]      level_q, level_d;
  logic [CW-1:0]   to_cnt_q, to_cnt_d;
  logic [3:0]      status_q, status_d;
  logic            irq_q, irq_d;

  logic [7:0]      mem_byte [FIFO_DEPTH];
  logic            mem_par  [FIFO_DEPTH];

  logic empty, full, push, pop, cap_ovf, busy_strobe, to_hit;
  logic [3:0] status_set;

  // FSM next state and receiver handshake outputs
  always_comb begin
    state_d         = state_q;
    cap_byte_d      = cap_byte_q;
    cap_par_d       = cap_par_q;
    rx_read_byte    = 1'b0;
    rx_clear_parity = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_stop_strobe) begin
          state_d    = ST_CAPTURE;
          cap_byte_d = rx_byte;
          cap_par_d  = rx_parity_err;
        end
      end
      ST_CAPTURE: state_d = ST_ACK;
      ST_ACK: begin
        state_d         = ST_IDLE;
        rx_read_byte    = 1'b1;
        rx_clear_parity = cap_par_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign empty       = (level_q == 5'd0);
  assign full        = (level_q == DEPTH_L);
  assign pop         = rd_en & ~empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push        = (state_q == ST_CAPTURE) & (~full | pop);
  assign cap_ovf     = (state_q == ST_CAPTURE) & full & ~pop;
  assign busy_strobe = rx_stop_strobe & (state_q != ST_IDLE);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    if (pop)  head_d = head_q + AW'(1);
    if (push) tail_d = tail_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase
  end

  // Idle timeout: counter sticks at its last value once reached, so the
  // flag re-asserts on later ticks until traffic resumes.
  always_comb begin
    to_cnt_d = to_cnt_q;
    to_hit   = 1'b0;
    if (push | pop | empty) begin
      to_cnt_d = '0;
    end else if (baud_tick & rx_idle) begin
      if (to_cnt_q == TO_LAST) to_hit = 1'b1;
      else                     to_cnt_d = to_cnt_q + CW'(1);
    end
  end

  assign status_set = {to_hit, rx_framing_err, pop & mem_par[head_q], cap_ovf | busy_strobe};

  always_comb begin
    status_d = status_set | (status_q & ~{4{clr_status}});
    irq_d    = irq_en & (((thresh != 5'd0) & (level_q >= thresh)) | (|status_q));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cap_byte_q <= 8'h00;
      cap_par_q  <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      level_q    <= 5'd0;
      to_cnt_q   <= '0;
      status_q   <= 4'b0000;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_byte_q <= cap_byte_d;
      cap_par_q  <= cap_par_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      level_q    <= level_d;
      to_cnt_q   <= to_cnt_d;
      status_q   <= status_d;
      irq_q      <= irq_d;
    end
  end

  // Storage needs no reset; rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_byte[tail_q] <= cap_byte_q;
      mem_par[tail_q]  <= cap_par_q;
    end
  end

  assign rd_data  = empty ? 8'h00 : mem_byte[head_q];
  assign rd_valid = ~empty;
  assign level    = level_q;
  assign status   = status_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed scenarios plus a randomized phase.
// Expected bytes are queued at stimulus time; a monitor pops and compares
// whenever the host pops a valid entry.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       baud_tick, rx_stop_strobe, rx_parity_err, rx_framing_err, rx_idle;
  logic [7:0] rx_byte;
  logic       rx_read_byte, rx_clear_parity;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] level;
  logic [4:0] thresh;
  logic       irq_en, clr_status;
  logic [3:0] status;
  logic       irq;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_TICKS(640)) dut (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick),
    .rx_stop_strobe(rx_stop_strobe), .rx_byte(rx_byte),
    .rx_parity_err(rx_parity_err), .rx_framing_err(rx_framing_err),
    .rx_idle(rx_idle), .rx_read_byte(rx_read_byte),
    .rx_clear_parity(rx_clear_parity), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .level(level), .thresh(thresh), .irq_en(irq_en),
    .clr_status(clr_status), .status(status), .irq(irq)
  );

  typedef struct { logic [7:0] b; logic p; } ent_t;
  ent_t sb[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   mcount = 0;
  logic exp_ov = 0, exp_fe = 0, exp_pe = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every host pop of a valid entry must match the queue head.
  always @(negedge clk) begin
    ent_t e;
    if (reset_n && rd_en) begin
      if (rd_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pop_unexpected: got %0h expected no data", rd_data);
        end else begin
          e = sb.pop_front();
          check("pop_data", rd_data, e.b);
          if (e.p) exp_pe = 1'b1;
        end
      end else if (sb.size() != 0) begin
        check("pop_valid", rd_valid, 1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Full receive transaction; checks ACK-cycle handshake and queues the
  // expected byte if there is room.
  task automatic do_strobe(input logic [7:0] b, input logic p);
    ent_t e;
    rx_byte = b; rx_parity_err = p; rx_stop_strobe = 1'b1;
    tick();
    rx_stop_strobe = 1'b0;
    if (mcount < DEPTH) begin
      e.b = b; e.p = p; sb.push_back(e); mcount++;
    end else exp_ov = 1'b1;
    tick();
    check("ack_read_byte", rx_read_byte, 1);
    check("ack_clear_parity", rx_clear_parity, p);
    check("ack_rd_valid", rd_valid, 1);
    tick();
    check("post_ack_read_byte", rx_read_byte, 0);
  endtask

  task automatic do_pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (mcount > 0) mcount--;
  endtask

  task automatic drain();
    while (mcount > 0) do_pop();
  endtask

  task automatic clear_status();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    exp_ov = 0; exp_fe = 0; exp_pe = 0;
  endtask

  initial begin
    logic [4:0] thr;
    ent_t       e;
    int         r;
    reset_n = 0; baud_tick = 0; rx_stop_strobe = 0; rx_byte = 0;
    rx_parity_err = 0; rx_framing_err = 0; rx_idle = 0; rd_en = 0;
    thresh = 0; irq_en = 0; clr_status = 0;
    ticks(2);
    check("rst_status", status, 0);
    check("rst_level", level, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_irq", irq, 0);
    check("rst_read_byte", rx_read_byte, 0);
    reset_n = 1;
    tick();

    // Single byte, no parity error
    do_strobe(8'hA5, 1'b0);
    check("a5_data", rd_data, 8'hA5);
    check("a5_level", level, 1);
    drain();
    check("empty_rd_data", rd_data, 0);
    check("empty_rd_valid", rd_valid, 0);

    // Five strobes into a 4-deep FIFO
    do_strobe(8'h11, 0); do_strobe(8'h22, 0); do_strobe(8'h33, 0);
    do_strobe(8'h44, 0); do_strobe(8'h55, 0);
    check("full_level", level, 4);
    check("full_status", status, 4'b0001);
    drain();
    clear_status();
    check("clr_status", status, 0);

    // Full FIFO: push and pop on the same CAPTURE edge
    do_strobe(8'h10, 0); do_strobe(8'h11, 0); do_strobe(8'h12, 0); do_strobe(8'h13, 0);
    rx_byte = 8'h99; rx_parity_err = 0; rx_stop_strobe = 1'b1;
    tick();
    rx_stop_strobe = 1'b0; rd_en = 1'b1;
    e.b = 8'h99; e.p = 1'b0; sb.push_back(e);
    tick();
    rd_en = 1'b0;
    check("pp_level", level, 4);
    check("pp_overflow", status[0], 0);
    check("pp_ack", rx_read_byte, 1);
    tick();
    drain();
    check("pp_status", status, 0);

    // Strobe while busy is discarded and flags overflow
    rx_byte = 8'h5A; rx_parity_err = 0; rx_stop_strobe = 1'b1;
    tick();
    rx_byte = 8'h6B;
    tick();
    rx_stop_strobe = 1'b0;
    e.b = 8'h5A; e.p = 1'b0; sb.push_back(e); mcount = 1;
    check("busy_ack", rx_read_byte, 1);
    tick();
    check("busy_ack_off", rx_read_byte, 0);
    check("busy_level", level, 1);
    check("busy_status", status, 4'b0001);
    drain();
    clear_status();

    // Idle timeout
    irq_en = 1; thresh = 0;
    do_strobe(8'h42, 0);
    rx_idle = 1;
    for (int i = 0; i < 639; i++) begin
      baud_tick = 1; tick(); baud_tick = 0; tick();
    end
    check("to_early", status[3], 0);
    baud_tick = 1; tick(); baud_tick = 0;
    check("to_status", status, 4'b1000);
    tick();
    check("to_irq", irq, 1);
    clear_status();
    check("to_clr_status", status, 0);
    tick();
    check("to_clr_irq", irq, 0);
    rx_idle = 0;
    drain();

    // Level threshold interrupt
    thresh = 2;
    do_strobe(8'h01, 0);
    tick();
    check("thr_irq1", irq, 0);
    do_strobe(8'h02, 0);
    check("thr_irq2", irq, 1);
    do_pop();
    tick();
    check("thr_irq_pop", irq, 0);
    drain();
    thresh = 0;
    tick();

    // Parity error byte
    do_strobe(8'hC3, 1'b1);
    check("par_pre_pop", status, 0);
    do_pop();
    check("par_status", status, 4'b0010);
    clear_status();
    irq_en = 0;
    tick();

    // Reset in CAPTURE abandons the byte
    rx_byte = 8'h77; rx_stop_strobe = 1'b1;
    tick();
    rx_stop_strobe = 1'b0;
    #2 reset_n = 0;
    #1;
    check("rstcap_read_byte", rx_read_byte, 0);
    check("rstcap_level", level, 0);
    tick();
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstcap_no_ack", rx_read_byte, 0);
    end
    check("rstcap_rd_valid", rd_valid, 0);

    // Randomized phase
    for (int it = 0; it < 300; it++) begin
      irq_en = 1'($urandom_range(0, 1));
      thr    = 5'($urandom_range(0, 5));
      thresh = thr;
      r = $urandom_range(0, 9);
      if (r <= 3) do_strobe(8'($urandom), 1'($urandom_range(0, 1)));
      else if (r <= 6) do_pop();
      else if (r == 7) begin
        rx_framing_err = 1; tick(); rx_framing_err = 0; exp_fe = 1;
      end else if (r == 8) clear_status();
      tick();
      check("rnd_level", level, mcount);
      check("rnd_rd_valid", rd_valid, (mcount != 0));
      check("rnd_status", status, {1'b0, exp_fe, exp_pe, exp_ov});
      tick();
      check("rnd_irq", irq, irq_en & (((thr != 0) && (mcount >= thr)) || exp_fe || exp_pe || exp_ov));
    end
    drain();
    tick();
    check("end_empty", rd_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
